// File: rtl/uart_pkg.sv
// Shared definitions for the UART packet parser: FSM state type, error codes,
// default sync marker and the buffer address-width helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_LEN,
    ST_PAYLOAD,
    ST_CKSUM,
    ST_SEND
  } state_e;

  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CKSUM   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Address width for a buffer of the given depth; never narrower than one bit.
  function automatic int unsigned buf_addr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/uart_pkt_buf.sv
// Payload byte RAM: one write port and one registered read port with
// write-through bypass so a same-cycle write to the read address is seen.
module uart_pkt_buf
  import uart_pkg::*;
#(
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned AW      = buf_addr_w(MAX_LEN)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [7:0]    wr_data_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [7:0]    rd_data_o
);

  logic [7:0] mem_q [MAX_LEN];
  logic [7:0] rd_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q <= '0;
    end else if (rd_en_i) begin
      if (we_i && (wr_addr_i == rd_addr_i)) begin
        rd_q <= wr_data_i;
      end else begin
        rd_q <= mem_q[rd_addr_i];
      end
    end
  end

  assign rd_data_o = rd_q;

endmodule

// File: rtl/uart_pkt_parser.sv
// Framed-packet parser behind the UART receiver: SYNC, LEN, payload[, CKSUM],
// then a valid/ready payload stream. Define UART_PKT_CKSUM_EN to verify the checksum.
module uart_pkt_parser
  import uart_pkg::*;
#(
  parameter int unsigned MAX_LEN      = 16,
  parameter logic [7:0]  SYNC_BYTE    = DEFAULT_SYNC_BYTE,
  parameter int unsigned TIMEOUT_CLKS = 312510
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Data_Valid,
  input  logic [7:0] Rx_Byte,
  output logic [7:0] Pkt_Byte,
  output logic       Pkt_Valid,
  output logic       Pkt_Last,
  input  logic       Pkt_Ready,
  output logic       Err,
  output logic [1:0] Err_Code,
  output logic       Ovr,
  output logic       Busy
);

  localparam int unsigned IDX_W = $clog2(MAX_LEN + 1);
  localparam int unsigned AW    = buf_addr_w(MAX_LEN);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CLKS);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   len_q, len_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TO_W-1:0]    to_q, to_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic               err_q, err_d;
  logic [1:0]         code_q, code_d;
  logic               ovr_q, ovr_d;
  logic               busy_q, busy_d;
`ifdef UART_PKT_CKSUM_EN
  logic [7:0]         sum_q, sum_d;
`endif

  logic               hs;
  logic               counting;
  logic               expire;
  logic               len_bad;
  logic [IDX_W-1:0]   idx_inc;
  logic [IDX_W-1:0]   len_m1;
  logic [TO_W-1:0]    to_inc;
  logic               buf_we;
  logic [IDX_W-1:0]   rd_idx;

  always_comb begin
    hs       = valid_q && Pkt_Ready;
    idx_inc  = idx_q + IDX_W'(1);
    len_m1   = len_q - IDX_W'(1);
    to_inc   = to_q + TO_W'(1);
    len_bad  = (Rx_Byte == 8'd0) || (32'(Rx_Byte) > MAX_LEN);
    counting = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CKSUM);
    // An arriving byte always beats a simultaneous expiry.
    expire   = counting && !Data_Valid && (to_inc == TO_W'(TIMEOUT_CLKS - 1));
    to_d     = (Data_Valid || !counting) ? '0 : to_inc;

    state_d  = state_q;
    len_d    = len_q;
    idx_d    = idx_q;
    valid_d  = valid_q;
    last_d   = last_q;
    err_d    = 1'b0;
    code_d   = code_q;
    ovr_d    = 1'b0;
    buf_we   = 1'b0;
    rd_idx   = '0;
`ifdef UART_PKT_CKSUM_EN
    sum_d    = sum_q;
`endif

    case (state_q)
      ST_HUNT: begin
        if (Data_Valid && (Rx_Byte == SYNC_BYTE)) begin
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (Data_Valid) begin
          if (len_bad) begin
            err_d   = 1'b1;
            code_d  = ERR_LEN;
            state_d = ST_HUNT;
          end else begin
            len_d   = IDX_W'(Rx_Byte);
            idx_d   = '0;
            state_d = ST_PAYLOAD;
`ifdef UART_PKT_CKSUM_EN
            sum_d   = Rx_Byte;
`endif
          end
        end else if (expire) begin
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
          state_d = ST_HUNT;
        end
      end
      ST_PAYLOAD: begin
        if (Data_Valid) begin
          buf_we = 1'b1;
          idx_d  = idx_inc;
`ifdef UART_PKT_CKSUM_EN
          sum_d  = sum_q + Rx_Byte;
          if (idx_inc == len_q) begin
            state_d = ST_CKSUM;
          end
`else
          // Read port prefetches buffer[0] now; the bypass covers L == 1.
          if (idx_inc == len_q) begin
            state_d = ST_SEND;
            idx_d   = '0;
            valid_d = 1'b1;
            last_d  = (len_q == IDX_W'(1));
          end
`endif
        end else if (expire) begin
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
          state_d = ST_HUNT;
        end
      end
      ST_CKSUM: begin
`ifdef UART_PKT_CKSUM_EN
        if (Data_Valid) begin
          if ((sum_q + Rx_Byte) == 8'd0) begin
            state_d = ST_SEND;
            idx_d   = '0;
            valid_d = 1'b1;
            last_d  = (len_q == IDX_W'(1));
          end else begin
            err_d   = 1'b1;
            code_d  = ERR_CKSUM;
            state_d = ST_HUNT;
          end
        end else if (expire) begin
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
          state_d = ST_HUNT;
        end
`else
        state_d = ST_HUNT;
`endif
      end
      ST_SEND: begin
        rd_idx = idx_q;
        if (hs && last_q) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          idx_d   = '0;
          state_d = (Data_Valid && (Rx_Byte == SYNC_BYTE)) ? ST_LEN : ST_HUNT;
        end else begin
          if (hs) begin
            idx_d  = idx_inc;
            rd_idx = idx_inc;
            last_d = (idx_inc == len_m1);
          end
          if (Data_Valid) begin
            ovr_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_HUNT;
      end
    endcase

    busy_d = (state_d != ST_HUNT);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_HUNT;
      len_q   <= '0;
      idx_q   <= '0;
      to_q    <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef UART_PKT_CKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      to_q    <= to_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      err_q   <= err_d;
      code_q  <= code_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
`ifdef UART_PKT_CKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  uart_pkt_buf #(
    .MAX_LEN (MAX_LEN),
    .AW      (AW)
  ) u_buf (
    .clk_i     (Clk),
    .rst_i     (Rst),
    .we_i      (buf_we),
    .wr_addr_i (AW'(idx_q)),
    .wr_data_i (Rx_Byte),
    .rd_en_i   (state_d == ST_SEND),
    .rd_addr_i (AW'(rd_idx)),
    .rd_data_o (Pkt_Byte)
  );

  assign Pkt_Valid = valid_q;
  assign Pkt_Last  = last_q;
  assign Err       = err_q;
  assign Err_Code  = code_q;
  assign Ovr       = ovr_q;
  assign Busy      = busy_q;

endmodule

// File: tb/tb_uart_pkt_parser.sv
// Scoreboard bench for uart_pkt_parser: directed frames push expected payload,
// error and overrun events; a negedge monitor pops and compares them.
module tb_uart_pkt_parser;

  localparam int unsigned TB_MAX_LEN = 16;
  localparam int unsigned TB_TIMEOUT = 40;
  localparam int unsigned GAP        = 2;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } pkt_t;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       Data_Valid;
  logic [7:0] Rx_Byte;
  logic [7:0] Pkt_Byte;
  logic       Pkt_Valid;
  logic       Pkt_Last;
  logic       Pkt_Ready;
  logic       Err;
  logic [1:0] Err_Code;
  logic       Ovr;
  logic       Busy;

  int nchecks = 0;
  int nerr    = 0;
  int exp_ovr = 0;
  pkt_t       exp_pkt_q[$];
  logic [1:0] exp_err_q[$];

  always #5 Clk = ~Clk;

  uart_pkt_parser #(
    .MAX_LEN      (TB_MAX_LEN),
    .SYNC_BYTE    (8'hA5),
    .TIMEOUT_CLKS (TB_TIMEOUT)
  ) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Data_Valid (Data_Valid),
    .Rx_Byte    (Rx_Byte),
    .Pkt_Byte   (Pkt_Byte),
    .Pkt_Valid  (Pkt_Valid),
    .Pkt_Last   (Pkt_Last),
    .Pkt_Ready  (Pkt_Ready),
    .Err        (Err),
    .Err_Code   (Err_Code),
    .Ovr        (Ovr),
    .Busy       (Busy)
  );

  task automatic check(input string name, input int act, input int exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    Data_Valid = 1'b1;
    Rx_Byte    = b;
    @(posedge Clk);
    #1;
    Data_Valid = 1'b0;
  endtask

  task automatic send_seq(input bq_t s);
    foreach (s[i]) begin
      send_byte(s[i]);
      if (i != s.size() - 1) idle(GAP);
    end
  endtask

  function automatic bq_t with_ck(input bq_t f, input logic [7:0] ck);
    bq_t r;
    r = f;
`ifdef UART_PKT_CKSUM_EN
    r.push_back(ck);
`endif
    return r;
  endfunction

  task automatic push_pkt(input logic [7:0] d, input logic l);
    pkt_t p;
    p.data = d;
    p.last = l;
    exp_pkt_q.push_back(p);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 100; i++) begin
      if (!Busy) break;
      idle(1);
    end
    check(name, Busy, 0);
  endtask

  // Monitor: every handshake, Err or Ovr must match a queued expectation.
  always @(negedge Clk) begin
    if (!Rst) begin
      if (Pkt_Valid && Pkt_Ready) begin
        if (exp_pkt_q.size() == 0) begin
          check("unexpected_pkt_byte", 32'(Pkt_Byte), 32'h1FF);
        end else begin
          pkt_t e;
          e = exp_pkt_q.pop_front();
          check("pkt_byte", 32'(Pkt_Byte), 32'(e.data));
          check("pkt_last", 32'(Pkt_Last), 32'(e.last));
        end
      end
      if (Err) begin
        if (exp_err_q.size() == 0) begin
          check("unexpected_err", 32'(Err_Code), 32'h1FF);
        end else begin
          logic [1:0] c;
          c = exp_err_q.pop_front();
          check("err_code", 32'(Err_Code), 32'(c));
        end
      end
      if (Ovr) begin
        check("ovr_expected", (exp_ovr > 0) ? 1 : 0, 1);
        if (exp_ovr > 0) exp_ovr--;
      end
    end
  end

  initial begin
    int k;
    Rst        = 1'b1;
    Data_Valid = 1'b0;
    Rx_Byte    = 8'h00;
    Pkt_Ready  = 1'b1;
    idle(3);
    check("rst_pkt_byte",  32'(Pkt_Byte),  0);
    check("rst_pkt_valid", 32'(Pkt_Valid), 0);
    check("rst_pkt_last",  32'(Pkt_Last),  0);
    check("rst_err",       32'(Err),       0);
    check("rst_err_code",  32'(Err_Code),  0);
    check("rst_ovr",       32'(Ovr),       0);
    check("rst_busy",      32'(Busy),      0);
    Rst = 1'b0;
    idle(2);

    // Good frame: 03+11+22+33 = 69, checksum 97
    push_pkt(8'h11, 1'b0);
    push_pkt(8'h22, 1'b0);
    push_pkt(8'h33, 1'b1);
    send_seq(with_ck('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33}, 8'h97));
    check("valid_rise", 32'(Pkt_Valid), 1);
    check("first_byte_on_rise", 32'(Pkt_Byte), 32'h11);
    check("busy_in_send", 32'(Busy), 1);
    wait_idle("busy_fall_good");
    idle(3);

`ifdef UART_PKT_CKSUM_EN
    // Bad checksum, then a good frame (02+44+55 = 9B, checksum 65)
    exp_err_q.push_back(2'd2);
    send_seq('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h98});
    check("bad_ck_err", 32'(Err), 1);
    idle(3);
    check("bad_ck_hunt", 32'(Busy), 0);
    push_pkt(8'h44, 1'b0);
    push_pkt(8'h55, 1'b1);
    send_seq('{8'hA5, 8'h02, 8'h44, 8'h55, 8'h65});
    wait_idle("busy_fall_after_bad_ck");
    idle(3);
`endif

    // Length errors: zero and MAX_LEN+1
    exp_err_q.push_back(2'd1);
    send_seq('{8'hA5, 8'h00});
    check("len0_err", 32'(Err), 1);
    idle(1);
    check("len0_err_single", 32'(Err), 0);
    check("len0_hunt", 32'(Busy), 0);
    idle(2);
    exp_err_q.push_back(2'd1);
    send_seq('{8'hA5, 8'h11});
    check("len17_err", 32'(Err), 1);
    check("len17_hunt", 32'(Busy), 0);
    idle(3);

    // Single-byte payload: 01+77 = 78, checksum 88
    push_pkt(8'h77, 1'b1);
    send_seq(with_ck('{8'hA5, 8'h01, 8'h77}, 8'h88));
    check("len1_last_on_rise", 32'(Pkt_Last), 1);
    wait_idle("busy_fall_len1");
    idle(3);

    // Stall after first payload byte
    exp_err_q.push_back(2'd3);
    send_seq('{8'hA5, 8'h02, 8'h11});
    k = 1;
    while (!Err && k < 200) begin
      idle(1);
      k++;
    end
    check("timeout_latency", k, int'(TB_TIMEOUT));
    check("timeout_code", 32'(Err_Code), 3);
    idle(1);
    check("timeout_err_single", 32'(Err), 0);
    check("timeout_hunt", 32'(Busy), 0);
    idle(3);

    // Backpressure with an overrun byte injected during SEND
    Pkt_Ready = 1'b0;
    send_seq(with_ck('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33}, 8'h97));
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", 32'(Pkt_Valid), 1);
      check("hold_byte", 32'(Pkt_Byte), 32'h11);
      check("hold_last", 32'(Pkt_Last), 0);
      idle(1);
    end
    exp_ovr++;
    send_byte(8'h55);
    check("ovr_pulse", 32'(Ovr), 1);
    check("ovr_byte_kept", 32'(Pkt_Byte), 32'h11);
    idle(1);
    check("ovr_single", 32'(Ovr), 0);
    push_pkt(8'h11, 1'b0);
    push_pkt(8'h22, 1'b0);
    push_pkt(8'h33, 1'b1);
    Pkt_Ready = 1'b1;
    wait_idle("busy_fall_bp");
    idle(3);

    // Leading garbage before a good frame
    push_pkt(8'h44, 1'b0);
    push_pkt(8'h55, 1'b1);
    send_seq(with_ck('{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h02, 8'h44, 8'h55}, 8'h65));
    wait_idle("busy_fall_garbage");
    idle(3);

    // Reset in the middle of a payload
    send_seq('{8'hA5, 8'h03, 8'h11});
    idle(1);
    check("pre_rst_busy", 32'(Busy), 1);
    Rst = 1'b1;
    idle(1);
    check("mid_rst_pkt_byte",  32'(Pkt_Byte),  0);
    check("mid_rst_pkt_valid", 32'(Pkt_Valid), 0);
    check("mid_rst_pkt_last",  32'(Pkt_Last),  0);
    check("mid_rst_err",       32'(Err),       0);
    check("mid_rst_err_code",  32'(Err_Code),  0);
    check("mid_rst_ovr",       32'(Ovr),       0);
    check("mid_rst_busy",      32'(Busy),      0);
    Rst = 1'b0;
    idle(2);
    push_pkt(8'h77, 1'b1);
    send_seq(with_ck('{8'hA5, 8'h01, 8'h77}, 8'h88));
    wait_idle("busy_fall_after_rst");

    idle(5);
    check("pkt_queue_drained", exp_pkt_q.size(), 0);
    check("err_queue_drained", exp_err_q.size(), 0);
    check("ovr_all_seen", exp_ovr, 0);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule

// File: doc/uart_pkt_parser.md
# uart_pkt_parser

Framed-packet parser that sits directly downstream of the UART receiver and consumes its one-cycle `Data_Valid` / `Rx_Byte` strobes. It hunts for a sync byte, reads a length byte, buffers the payload, and optionally verifies a checksum. Only a fully validated payload is released, byte by byte, to the command layer over a valid/ready stream. Malformed, stalled or overrun frames are discarded and reported.

## Interface
Parameters:
- `MAX_LEN`, 16: maximum payload bytes. Range 1..255.
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `TIMEOUT_CLKS`, 312510: inter-byte timeout in clocks (3 byte-times at 10417 clocks/bit).

Ports (one clock; reset is synchronous and active-high):
- `Clk`  in  1  system clock.
- `Rst`  in  1  synchronous active-high reset.
- `Data_Valid`  in  1  one-cycle strobe from the UART receiver.
- `Rx_Byte`  in  8  received byte; qualified by `Data_Valid`.
- `Pkt_Byte`  out  8  payload byte.
- `Pkt_Valid`  out  1  `Pkt_Byte` is valid.
- `Pkt_Last`  out  1  marks the final payload byte.
- `Pkt_Ready`  in  1  consumer accepts the byte.
- `Err`  out  1  one-cycle pulse; a frame was discarded.
- `Err_Code`  out  2  cause, held until the next `Err`: 1 = bad length, 2 = bad checksum, 3 = timeout.
- `Ovr`  out  1  one-cycle pulse; a byte arrived during SEND and was dropped.
- `Busy`  out  1  high in every state except HUNT.

## Operation
- States: HUNT, LEN, PAYLOAD, CKSUM, SEND.
- HUNT: on a byte equal to `SYNC_BYTE`, go to LEN. All other bytes are ignored silently.
- LEN: latch the byte as L.
  - If L == 0 or L > `MAX_LEN`: pulse `Err`, set code 1, go to HUNT.
  - Otherwise go to PAYLOAD. The running sum is loaded with L.
- PAYLOAD: write each byte to buffer[idx], add it to the running sum, and increment idx. After byte L, go to CKSUM.
- CKSUM: frame is good when (sum + byte) mod 256 == 0.
  - Good: go to SEND.
  - Bad: pulse `Err`, set code 2, go to HUNT.
- SEND: present buffer[0..L-1] in order.
  - A byte advances only on `Pkt_Valid` && `Pkt_Ready`.
  - `Pkt_Last` is asserted together with byte L-1.
  - The handshake on the last byte returns the state to HUNT.
- Timeout: the counter clears on every `Data_Valid` and counts while in LEN, PAYLOAD or CKSUM. On reaching `TIMEOUT_CLKS`-1: pulse `Err`, set code 3, go to HUNT.
- Arithmetic: sum is 8-bit and wraps. idx is $clog2(`MAX_LEN`+1) bits. The timeout counter is $clog2(`TIMEOUT_CLKS`) bits.

## Timing
- Reset values: `Pkt_Byte`=0, `Pkt_Valid`=0, `Pkt_Last`=0, `Err`=0, `Err_Code`=0, `Ovr`=0, `Busy`=0. State is HUNT; idx, sum and timeout counter are 0.
- `Err` rises on the cycle after the offending `Data_Valid`, or after the counter expiry. It is a single-cycle pulse.
- `Pkt_Valid` rises on the cycle after the checksum byte's `Data_Valid`. With the checksum compiled out, it rises on the cycle after the last payload byte.
- Throughput in SEND: one byte per clock while `Pkt_Ready` is high.
- `Pkt_Byte` and `Pkt_Last` are stable while `Pkt_Valid` is high and `Pkt_Ready` is low.
- The input has no backpressure. A `Data_Valid` in SEND pulses `Ovr` on the next cycle; the byte is dropped and SEND continues.
- Simultaneous `Data_Valid` and timeout expiry: the byte wins. The counter clears and the byte is processed.
- A `Data_Valid` in the same cycle as the final SEND handshake is treated as a HUNT-state byte. If it equals `SYNC_BYTE`, the next state is LEN.
- Reset mid-frame or mid-SEND: state returns to HUNT immediately and outputs take their reset values. Buffer contents are don't-care.

## Configuration
- `UART_PKT_CKSUM_EN` defined: frame is SYNC, LEN, payload, CKSUM. The checksum is verified and error code 2 is possible.
- Not defined: frame is SYNC, LEN, payload. PAYLOAD goes directly to SEND, there is no sum logic, and code 2 is never produced.

## Structure
- Shared package `uart_pkg`:
  - state enum type;
  - error-code constants `ERR_LEN` (1), `ERR_CKSUM` (2), `ERR_TIMEOUT` (3);
  - default `SYNC_BYTE`.
- Sub-module `uart_pkt_buf`: byte RAM, `MAX_LEN` deep, one write port and one synchronous read port. Read data is prefetched so `Pkt_Byte` is valid on `Pkt_Valid` rise.

## Test plan
- Good frame A5 03 11 22 33 97:
  - `Pkt_Byte` sequence 11, 22, 33;
  - `Pkt_Last` on 33;
  - no `Err`;
  - `Busy` falls after the last handshake.
- Frame A5 03 11 22 33 98 -> `Err` pulse, `Err_Code`=2, no `Pkt_Valid`. A following good frame is parsed correctly.
- Length errors:
  - A5 00 -> `Err_Code`=1.
  - A5 11 with `MAX_LEN`=16 -> `Err_Code`=1.
  - Both return to HUNT.
- Stall: A5 02 11 then idle -> `Err` exactly `TIMEOUT_CLKS` clocks after the 11 strobe, `Err_Code`=3.
- Backpressure and overrun:
  - Good frame with `Pkt_Ready` low for 5 cycles -> `Pkt_Byte` 11 held.
  - Byte 55 injected during SEND -> `Ovr` pulse; payload unchanged.
- Leading garbage 00 FF 5A before a good frame -> ignored, payload delivered. `Rst` asserted mid-PAYLOAD -> all outputs 0 and state HUNT on the next cycle.
